// File: rtl/instr_buffer_pkg.sv
// rtl/instr_buffer_pkg.sv - shared packet types and buffer sizing for the instruction buffer
package instr_buffer_pkg;

`ifndef IB_SZ
`define IB_SZ 8
`endif

    localparam int IB_SZ = `IB_SZ;

    typedef struct packed {
        logic [31:0] PC;
        logic [31:0] inst;
        logic [4:0]  dest_reg_idx;
        logic        valid;
    } DP_PACKET;

    typedef struct packed {
        logic        squash_valid;
        logic [31:0] squash_pc;
    } SQUASH_PACKET;

    // Pointer width that stays legal for a degenerate single-entry depth.
    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/instr_buffer_if.sv
// rtl/instr_buffer_if.sv - decode/dispatch handshake bundle around the instruction buffer
interface instr_buffer_if import instr_buffer_pkg::*; #(
    parameter int DEPTH = IB_SZ
) ();
    DP_PACKET                     id_ib_packet;
    logic                         id_ib_valid;
    logic                         ib_id_ready;
    logic                         rob_dp_available;
    logic                         rs_dp_available;
    logic                         squash_valid;
    DP_PACKET                     ib_dp_packet;
    logic                         ib_dp_valid;
    logic [$clog2(DEPTH+1)-1:0]   ib_count;

    modport master (
        output id_ib_packet, id_ib_valid, rob_dp_available, rs_dp_available, squash_valid,
        input  ib_id_ready, ib_dp_packet, ib_dp_valid, ib_count
    );

    modport slave (
        input  id_ib_packet, id_ib_valid, rob_dp_available, rs_dp_available, squash_valid,
        output ib_id_ready, ib_dp_packet, ib_dp_valid, ib_count
    );
endinterface

// File: rtl/instr_buffer_ib_ptr.sv
// rtl/instr_buffer_ib_ptr.sv - wrapping head/tail pointer register for non power-of-two depths
module ib_ptr import instr_buffer_pkg::*; #(
    parameter int DEPTH = IB_SZ
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        i_adv,
    input  logic                        i_clr,
    output logic [ptr_bits(DEPTH)-1:0]  o_ptr
);
    localparam int            PW   = ptr_bits(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0] r_ptr;

    always_ff @(posedge clock) begin
        if (!reset || i_clr) begin
            r_ptr <= '0;
        end else if (i_adv) begin
            r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/instr_buffer.sv
// rtl/instr_buffer.sv - circular decode-to-dispatch buffer with squash flush
// Optional same-cycle empty-buffer bypass: define IB_BYPASS_EN.
module instr_buffer import instr_buffer_pkg::*; #(
    parameter int IB_DEPTH = IB_SZ
) (
    input  logic           clock,
    input  logic           reset,
    instr_buffer_if.slave  ib
);
    localparam int            PW   = ptr_bits(IB_DEPTH);
    localparam int            CW   = $clog2(IB_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(IB_DEPTH);

    DP_PACKET      r_entries [IB_DEPTH];
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_head;
    logic [PW-1:0] w_tail;
    logic          w_ready;
    logic          w_stored;
    logic          w_bypass;
    logic          w_valid;
    logic          w_deq;
    logic          w_enq_eff;
    logic          w_deq_eff;
    DP_PACKET      w_pkt;

    assign w_ready  = (r_count != FULL);
    assign w_stored = (r_count != '0);

`ifdef IB_BYPASS_EN
    assign w_bypass = !w_stored && ib.id_ib_valid && !ib.squash_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_valid = w_stored || w_bypass;
    assign w_pkt   = w_stored ? r_entries[w_head] : (w_bypass ? ib.id_ib_packet : '0);
    assign w_deq   = w_valid && ib.rob_dp_available && ib.rs_dp_available;

    // A bypassed packet that dispatches immediately never occupies a slot.
    assign w_enq_eff = ib.id_ib_valid && w_ready && !(w_bypass && w_deq);
    assign w_deq_eff = w_deq && w_stored;

    ib_ptr #(.DEPTH(IB_DEPTH)) u_head (
        .clock (clock),
        .reset (reset),
        .i_adv (w_deq_eff),
        .i_clr (ib.squash_valid),
        .o_ptr (w_head)
    );

    ib_ptr #(.DEPTH(IB_DEPTH)) u_tail (
        .clock (clock),
        .reset (reset),
        .i_adv (w_enq_eff),
        .i_clr (ib.squash_valid),
        .o_ptr (w_tail)
    );

    always_ff @(posedge clock) begin
        if (!reset || ib.squash_valid) begin
            for (int i = 0; i < IB_DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (w_deq_eff) begin
                r_entries[w_head] <= '0;
            end
            if (w_enq_eff) begin
                r_entries[w_tail] <= ib.id_ib_packet;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || ib.squash_valid) begin
            r_count <= '0;
        end else begin
            case ({w_enq_eff, w_deq_eff})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign ib.ib_id_ready  = w_ready;
    assign ib.ib_dp_valid  = w_valid;
    assign ib.ib_dp_packet = w_pkt;
    assign ib.ib_count     = r_count;
endmodule

// File: tb/tb_instr_buffer.sv
// tb/tb_instr_buffer.sv - randomized scoreboard bench for instr_buffer against a queue model
module tb_instr_buffer;
    import instr_buffer_pkg::*;

    localparam int D = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    instr_buffer_if #(.DEPTH(D)) ibus ();

    instr_buffer #(.IB_DEPTH(D)) dut (
        .clock (clock),
        .reset (reset),
        .ib    (ibus)
    );

    int       compared   = 0;
    int       mismatched = 0;
    int       max_cnt    = 0;
    bit       mon_en     = 1'b0;
    DP_PACKET mdl [$];
    DP_PACKET sb  [$];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit bypass_now();
`ifdef IB_BYPASS_EN
        return (mdl.size() == 0) && ibus.id_ib_valid && !ibus.squash_valid;
`else
        return 1'b0;
`endif
    endfunction

    function automatic DP_PACKET mk(input logic [31:0] pc);
        DP_PACKET p;
        p.PC           = pc;
        p.inst         = $urandom;
        p.dest_reg_idx = 5'($urandom_range(0, 31));
        p.valid        = 1'b1;
        return p;
    endfunction

    // Monitor: checks registered-state outputs and pops the scoreboard on each dispatch.
    DP_PACKET m_exp;
    bit       m_valid;
    always @(negedge clock) begin
        if (mon_en) begin
            m_valid = (mdl.size() != 0) || bypass_now();
            chk("count", 96'(ibus.ib_count), 96'(mdl.size()));
            chk("ready", 96'(ibus.ib_id_ready), 96'(mdl.size() != D));
            chk("valid", 96'(ibus.ib_dp_valid), 96'(m_valid));
            if (!m_valid) chk("idle_pkt", 96'(ibus.ib_dp_packet), 96'(0));
            if (ibus.squash_valid) begin
                sb.delete();
            end else if (m_valid && ibus.rob_dp_available && ibus.rs_dp_available) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL sb_underflow: got dispatch of %0h expected none", ibus.ib_dp_packet.PC);
                end else begin
                    m_exp = sb.pop_front();
                    chk("deq_pkt", 96'(ibus.ib_dp_packet), 96'(m_exp));
                end
            end
        end
    end

    // Driver: called just after a posedge; holds inputs for one cycle and updates the model.
    task automatic cyc(input bit v, input DP_PACKET p, input bit rob, input bit rs, input bit sq);
        bit enq, deq;
        ibus.id_ib_valid      = v;
        ibus.id_ib_packet     = p;
        ibus.rob_dp_available = rob;
        ibus.rs_dp_available  = rs;
        ibus.squash_valid     = sq;
        enq = v && (mdl.size() != D) && !sq;
        deq = rob && rs && !sq && ((mdl.size() != 0) || bypass_now());
        if (enq) sb.push_back(p);
        @(posedge clock);
        #1;
        if (sq) begin
            mdl.delete();
        end else begin
            if (enq) mdl.push_back(p);
            if (deq) void'(mdl.pop_front());
        end
        if (mdl.size() > max_cnt) max_cnt = mdl.size();
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * D && mdl.size() != 0; i++) cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("drained", 96'(ibus.ib_count), 96'(0));
    endtask

    initial begin
        ibus.id_ib_valid      = 1'b0;
        ibus.id_ib_packet     = '0;
        ibus.rob_dp_available = 1'b0;
        ibus.rs_dp_available  = 1'b0;
        ibus.squash_valid     = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_valid", 96'(ibus.ib_dp_valid), 96'(0));
        chk("rst_pkt", 96'(ibus.ib_dp_packet), 96'(0));
        chk("rst_count", 96'(ibus.ib_count), 96'(0));
        chk("rst_ready", 96'(ibus.ib_id_ready), 96'(1));
        @(posedge clock);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < D; i++) cyc(1'b1, mk(32'(i * 4)), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, mk(32'h20), 1'b0, 1'b0, 1'b0);
        chk("fill_count", 96'(ibus.ib_count), 96'(8));
        chk("fill_ready", 96'(ibus.ib_id_ready), 96'(0));
        chk("fill_head_pc", 96'(ibus.ib_dp_packet.PC), 96'(0));

        for (int i = 0; i < D; i++) begin
            chk("drain_pc", 96'(ibus.ib_dp_packet.PC), 96'(i * 4));
            cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
        end
        chk("drain_valid", 96'(ibus.ib_dp_valid), 96'(0));
        chk("drain_count", 96'(ibus.ib_count), 96'(0));

        for (int i = 0; i < 3; i++) cyc(1'b1, mk(32'(32'h200 + i * 4)), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, mk(32'h20c), 1'b1, 1'b1, 1'b0);
        chk("both_count3", 96'(ibus.ib_count), 96'(3));
        for (int i = 0; i < 5; i++) cyc(1'b1, mk(32'(32'h210 + i * 4)), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, mk(32'h2ff), 1'b1, 1'b1, 1'b0);
        chk("full_deq_ready", 96'(ibus.ib_id_ready), 96'(1));
        chk("full_deq_count", 96'(ibus.ib_count), 96'(7));
        drain();

        for (int i = 0; i < 20; i++) cyc(1'b1, mk(32'(32'h100 + i * 4)), 1'(i % 2), 1'b1, 1'b0);
        drain();

        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 3) != 0), mk($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0));
        drain();

        for (int i = 0; i < 5; i++) cyc(1'b1, mk(32'(32'h300 + i * 4)), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, mk(32'h314), 1'b1, 1'b1, 1'b1);
        chk("sq_count", 96'(ibus.ib_count), 96'(0));
        chk("sq_valid", 96'(ibus.ib_dp_valid), 96'(0));
        chk("sq_pkt", 96'(ibus.ib_dp_packet), 96'(0));
        cyc(1'b1, mk(32'h40), 1'b0, 1'b0, 1'b0);
        chk("post_sq_count", 96'(ibus.ib_count), 96'(1));
        chk("post_sq_pc", 96'(ibus.ib_dp_packet.PC), 96'(32'h40));
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("post_sq_empty", 96'(ibus.ib_dp_valid), 96'(0));

        cyc(1'b1, mk(32'h80), 1'b1, 1'b1, 1'b0);
`ifdef IB_BYPASS_EN
        chk("byp_count", 96'(ibus.ib_count), 96'(0));
`else
        chk("byp_count", 96'(ibus.ib_count), 96'(1));
        chk("byp_next_pc", 96'(ibus.ib_dp_packet.PC), 96'(32'h80));
`endif
        drain();
        chk("max_count_bound", 96'(max_cnt <= D), 96'(1));
        chk("sb_leftover", 96'(sb.size()), 96'(0));

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/instr_buffer.md
# instr_buffer

Circular instruction buffer between decode and dispatch. Holds decoded DP_PACKETs from the front end and presents the oldest one to dispatch, where it is sent to the ROB (as its new-tail source) and the RS in the same cycle. Absorbs ROB/RS back-pressure and empties completely on a branch-misprediction squash.

## Interface
- IB_DEPTH, default 8 — number of entries; any value ≥ 2, not required to be a power of two.
- clock  input  1  — single clock; all state updates on posedge.
- reset  input  1  — synchronous, active-low reset.
- id_ib_packet  input  DP_PACKET  — decoded instruction from decode.
- id_ib_valid  input  1  — id_ib_packet is valid this cycle.
- ib_id_ready  output  1  — buffer accepts an enqueue this cycle.
- rob_dp_available  input  1  — ROB can take a new tail this cycle.
- rs_dp_available  input  1  — RS has a free entry this cycle.
- squash_valid  input  1  — taken from SQUASH_PACKET.squash_valid; flush request.
- ib_dp_packet  output  DP_PACKET  — oldest buffered instruction.
- ib_dp_valid  output  1  — ib_dp_packet is valid.
- ib_count  output  $clog2(IB_DEPTH+1)  — current occupancy.

## Operation
- State: IB_DEPTH-entry DP_PACKET array, head and tail pointers ($clog2(IB_DEPTH) bits), count register.
- enq = id_ib_valid && ib_id_ready. deq = ib_dp_valid && rob_dp_available && rs_dp_available.
- ib_id_ready = (count != IB_DEPTH). Depends on registered count only; a dequeue in the same cycle does not free a slot for enqueue.
- ib_dp_valid = (count != 0). ib_dp_packet = entry[head] when valid, else '0.
- On enq: entry[tail] ← id_ib_packet; tail advances. On deq: entry[head] ← '0; head advances.
- Pointer wrap: value IB_DEPTH-1 advances to 0 (explicit compare, no modulo via truncation).
- count: +1 on enq only, −1 on deq only, unchanged on both or neither. It never exceeds IB_DEPTH and never underflows.
- Squash: head, tail and count ← 0; all entries ← '0. A simultaneous enq and deq are both discarded. Squash takes priority over everything.
- Reset (reset==0 at posedge): same effect as squash. Reset takes priority over squash.

## Timing
- Reset values: ib_dp_valid=0, ib_dp_packet='0, ib_count=0, ib_id_ready=1.
- Enqueue-to-visible latency is 1 cycle: a packet enqueued at edge N appears on ib_dp_packet after edge N if the buffer was empty.
- Throughput is 1 enqueue plus 1 dequeue per cycle.
- Full with dequeue: ready=0, and ready rises the cycle after the dequeue.
- Empty with enqueue: valid=0 this cycle, and valid=1 next cycle.
- The cycle after a squash: valid=0, ready=1, count=0.
- Outputs are pure functions of registered state. There is no combinational path from rob_dp_available, rs_dp_available or id_ib_valid to any output.

## Configuration
- IB_BYPASS_EN defined: when count==0 and id_ib_valid, ib_dp_valid=1 and ib_dp_packet=id_ib_packet in the same cycle.
  - If deq also occurs that cycle, the packet is not written and count stays 0. Otherwise it is enqueued normally.
  - squash_valid suppresses the bypass (ib_dp_valid=0).
  - This adds a combinational path from id_ib_* to ib_dp_*.
- IB_BYPASS_EN undefined: the 1-cycle latency above applies strictly.

## Structure
- DP_PACKET and SQUASH_PACKET come from the shared sys_defs package.
- Add `IB_SZ (default 8) to sys_defs; the IB_DEPTH parameter defaults to it.
- One sub-module is natural: ib_ptr, a wrapping pointer register with advance and clear inputs and a DEPTH parameter, instantiated for head and tail.

## Test plan
- Reset then fill: hold rob/rs available=0 and enqueue 8 packets (PC 0x0–0x1C) → ib_count=8, ib_id_ready=0; a 9th enqueue is ignored and ib_dp_packet.PC=0x0.
- Drain: set both available=1 for 8 cycles → packets PC 0x0…0x1C appear in order; afterwards ib_dp_valid=0 and ib_count=0.
- Simultaneous enq/deq at count=3 → ib_count stays 3. At count=8 with deq → no enqueue, ib_id_ready=1 next cycle.
- Wrap-around: 20 cycles of streaming enq+deq with alternating back-pressure → FIFO order preserved across pointer wrap; ib_count never exceeds 8.
- Squash with count=5 plus enq and deq asserted the same cycle → next cycle ib_count=0, ib_dp_valid=0, ib_dp_packet='0; a later enqueue of PC 0x40 appears alone.
- Bypass: with IB_BYPASS_EN, when empty, enqueue PC 0x80 with rob/rs available → ib_dp_valid=1 the same cycle and ib_count=0 next cycle. Without the macro, ib_dp_valid=0 that cycle and 1 the next.
